seq_multiplier: RTL and testbench

//   Multi-cycle unsigned shift-and-add multiplier feeding a downstream

---
 rtl/seq_multiplier.sv | 94 +++++++++
 tb/tb_seq_multiplier.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned shift-and-add multiplier, one operand bit per cycle.
// Ports: clk, clr_n (sync active-low), start/a/b in; busy, done strobe, p (2N) out.
module seq_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [2*N-1:0] acc;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] acc_add;
  logic           last;

  // Accumulator value including this cycle's conditional add.
  assign acc_add = mplier[0] ? acc + mcand : acc;
  assign last    = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      p      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{N{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc    <= acc_add;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          // p is only written here, so it holds between results.
          if (last) p <= acc_add;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: table vectors, corner sequences and random ops
// checked every cycle against a latency/product reference model.
module tb_seq_multiplier;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           clr_n = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*N-1:0] p;

  seq_multiplier #(.N(N)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: 0 = idle, k = k-th cycle after an accepted start.
  int             phase = 0;
  logic [2*N-1:0] pend  = '0;
  logic [2*N-1:0] exp_p = '0;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] p;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic c, input logic s,
                      input logic [N-1:0] ia, input logic [N-1:0] ib);
    clr_n = c;
    start = s;
    a     = ia;
    b     = ib;
    @(posedge clk);
    #1;
    if (!c) begin
      phase = 0;
      exp_p = '0;
    end else if (phase == 0) begin
      if (s) begin
        phase = 1;
        pend  = (2*N)'(ia) * (2*N)'(ib);
      end
    end else if (phase == N + 1) begin
      phase = 0;
    end else begin
      phase++;
      if (phase == N + 1) exp_p = pend;
    end
    check("busy", 32'(busy), 32'(phase != 0));
    check("done", 32'(done), 32'(phase == N + 1));
    check("p", 32'(p), 32'(exp_p));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, '0, '0);
  endtask

  initial begin
    int dc;
    int nd;
    bit seen;

    vecs[0] = '{8'd3,   8'd5,   16'd15};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{8'd0,   8'd200, 16'd0};
    vecs[3] = '{8'd1,   8'd128, 16'd128};
    vecs[4] = '{8'd128, 8'd1,   16'd128};
    vecs[5] = '{8'd255, 8'd1,   16'd255};
    vecs[6] = '{8'd16,  8'd16,  16'd256};
    vecs[7] = '{8'd170, 8'd85,  16'h3872};

    // Reset state
    tick(1'b0, 1'b0, '0, '0);
    tick(1'b0, 1'b0, '0, '0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_p", 32'(p), 32'd0);

    // Latency: start in cycle 0, done only in cycle N+1
    dc = -1;
    nd = 0;
    tick(1'b1, 1'b1, 8'd3, 8'd5);
    for (int i = 2; i <= 12; i++) begin
      tick(1'b1, 1'b0, 8'd77, 8'd66);
      if (done) begin
        nd++;
        if (dc < 0) dc = i;
      end
    end
    check("t1_done_cycle", 32'(dc), 32'(N + 1));
    check("t1_done_count", 32'(nd), 32'd1);
    check("t1_p_held", 32'(p), 32'd15);

    // Table vectors
    foreach (vecs[k]) begin
      tick(1'b1, 1'b1, vecs[k].a, vecs[k].b);
      seen = 0;
      for (int i = 0; i < N + 4 && !seen; i++) begin
        tick(1'b1, 1'b0, ~vecs[k].a, ~vecs[k].b);
        if (done) seen = 1;
      end
      check("vec_timeout", 32'(seen), 32'd1);
      check("vec_p", 32'(p), 32'(vecs[k].p));
      idle(2);
    end

    // start held high from reset release: one result every N+2 cycles
    tick(1'b0, 1'b1, 8'd2, 8'd7);
    nd = 0;
    for (int i = 0; i < 3 * (N + 2); i++) begin
      tick(1'b1, 1'b1, 8'd2, 8'd7);
      if (done) begin
        nd++;
        check("held_p", 32'(p), 32'd14);
      end
    end
    check("held_count", 32'(nd), 32'd3);
    tick(1'b0, 1'b0, '0, '0);

    // Operand change and second start while busy are ignored
    tick(1'b1, 1'b1, 8'd10, 8'd20);
    tick(1'b1, 1'b0, 8'd10, 8'd20);
    tick(1'b1, 1'b0, 8'd10, 8'd20);
    tick(1'b1, 1'b1, 8'd99, 8'd99);
    nd = 0;
    for (int i = 0; i < 2 * N + 4; i++) begin
      tick(1'b1, 1'b0, 8'd99, 8'd99);
      if (done) begin
        nd++;
        check("chg_p", 32'(p), 32'd200);
      end
    end
    check("chg_count", 32'(nd), 32'd1);

    // Reset during RUN aborts
    tick(1'b1, 1'b1, 8'd6, 8'd7);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'd6, 8'd7);
    tick(1'b0, 1'b0, 8'd6, 8'd7);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_p", 32'(p), 32'd0);
    nd = 0;
    for (int i = 0; i < N + 4; i++) begin
      tick(1'b1, 1'b0, '0, '0);
      if (done) nd++;
    end
    check("abort_no_done", 32'(nd), 32'd0);

    // Reset and start at the same edge
    tick(1'b0, 1'b1, 8'd9, 8'd9);
    check("rs_busy", 32'(busy), 32'd0);
    idle(3);
    check("rs_idle", 32'(busy), 32'd0);
    tick(1'b1, 1'b1, 8'd9, 8'd9);
    idle(N + 1);
    check("rs_p", 32'(p), 32'd81);
    idle(1);

    // Random operations with start noise while busy
    for (int k = 0; k < 25; k++) begin
      tick(1'b1, 1'b1, N'($urandom), N'($urandom));
      for (int i = 0; i < N + 1; i++)
        tick(1'b1, 1'($urandom), N'($urandom), N'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
